// File: rtl/axi_nto1_mux_pkg.sv
// Shared widths and helpers for the N-to-1 AXI4 multiplexer.
// Payload layouts (MSB first), all packed with the ID at the top so that a
// master index can be prepended on the slave side by plain concatenation:
//   AW/AR : {id, addr, len[8], size[3], burst[2], lock[1], cache[4], prot[3], region[4], qos[4]}
//   W     : {data, strb, last}
//   B     : {id, resp[2]}
//   R     : {id, data, resp[2], last}
// Index, pointer and counter types depend on module parameters, so each
// module derives its own rr_ptr_t / cnt_t from the width functions here.
package axi_nto1_mux_pkg;

  localparam int unsigned AxCtrlW = 29;  // len + size + burst + lock + cache + prot + region + qos
  localparam int unsigned RespW   = 2;

  // Width of a master index; at least one bit even for a single master.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter must represent 0..max inclusive.
  function automatic int unsigned cnt_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

  function automatic int unsigned ax_w(input int unsigned id_w, input int unsigned addr_w);
    return id_w + addr_w + AxCtrlW;
  endfunction

  function automatic int unsigned w_w(input int unsigned data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int unsigned b_w(input int unsigned id_w);
    return id_w + RespW;
  endfunction

  function automatic int unsigned r_w(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w + RespW + 1;
  endfunction

endpackage

// File: rtl/axi_nto1_mux_if.sv
// Bundle of NoPorts AXI4 ports, each channel packed as NoPorts x payload.
// Modport master drives requests (AW/W/AR) and accepts responses (B/R);
// modport slave is the opposite view. The mux uses a slave view with
// NoPorts=NoMasters towards the masters and a master view with NoPorts=1
// and the widened ID towards the memory port.
interface axi_nto1_mux_if
  import axi_nto1_mux_pkg::*;
#(
  parameter int unsigned NoPorts   = 1,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned AxW = ax_w(IdWidth, AddrWidth);
  localparam int unsigned WW  = w_w(DataWidth);
  localparam int unsigned BW  = b_w(IdWidth);
  localparam int unsigned RW  = r_w(IdWidth, DataWidth);

  logic [NoPorts-1:0][AxW-1:0] aw;
  logic [NoPorts-1:0]          awvalid, awready;
  logic [NoPorts-1:0][WW-1:0]  w;
  logic [NoPorts-1:0]          wvalid, wready;
  logic [NoPorts-1:0][BW-1:0]  b;
  logic [NoPorts-1:0]          bvalid, bready;
  logic [NoPorts-1:0][AxW-1:0] ar;
  logic [NoPorts-1:0]          arvalid, arready;
  logic [NoPorts-1:0][RW-1:0]  r;
  logic [NoPorts-1:0]          rvalid, rready;

  modport master (
    output aw, awvalid, input awready,
    output w, wvalid, input wready,
    input b, bvalid, output bready,
    output ar, arvalid, input arready,
    input r, rvalid, output rready
  );

  modport slave (
    input aw, awvalid, output awready,
    input w, wvalid, output wready,
    output b, bvalid, input bready,
    input ar, arvalid, output arready,
    output r, rvalid, input rready
  );
endinterface

// File: rtl/axi_nto1_mux_rr_arb.sv
// Round-robin arbiter for one address channel.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   req_i         : per-requester eligibility
//   lock_i        : winner presented but not accepted this cycle; hold it next cycle
//   advance_i     : winner accepted this cycle; pointer moves past it
//   gnt_o, idx_o  : one-hot grant and its index
//   valid_o       : a grant is being presented
module axi_nto1_mux_rr_arb
  import axi_nto1_mux_pkg::*;
#(
  parameter int unsigned NoReq = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NoReq-1:0]          req_i,
  input  logic                      lock_i,
  input  logic                      advance_i,
  output logic [NoReq-1:0]          gnt_o,
  output logic [idx_w(NoReq)-1:0]   idx_o,
  output logic                      valid_o
);
  typedef logic [idx_w(NoReq)-1:0] rr_ptr_t;

  rr_ptr_t ptr_q, ptr_d, lock_idx_q;
  logic    lock_q;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int j;
    j       = 0;
    idx_o   = lock_idx_q;
    valid_o = 1'b0;
    if (lock_q) begin
      // AXI forbids withdrawing valid, so the held winner is still requesting.
      valid_o = req_i[lock_idx_q];
    end else begin
      for (int i = 0; i < int'(NoReq); i++) begin
        j = int'(ptr_q) + i;
        if (j >= int'(NoReq)) j = j - int'(NoReq);
        if (!valid_o && req_i[rr_ptr_t'(j)]) begin
          valid_o = 1'b1;
          idx_o   = rr_ptr_t'(j);
        end
      end
    end
    gnt_o        = '0;
    gnt_o[idx_o] = valid_o;
    ptr_d        = (idx_o == rr_ptr_t'(NoReq - 1)) ? '0 : idx_o + rr_ptr_t'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= lock_i;
      if (lock_i) lock_idx_q <= idx_o;
      if (advance_i) ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/axi_nto1_mux.sv
// N-master to 1-slave AXI4 multiplexer.
// Round-robin AW/AR arbitration with the master index prepended to the ID,
// W routed by an in-order grant FIFO, B/R routed back by the ID MSBs, and a
// per-master cap on outstanding reads and writes.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   mst           : NoMasters master ports (slave view), ID width AxiIdWidth
//   slv           : single memory-side port (master view), ID width AxiIdWidth+IdxW
// Build option: define AXI_NTO1_MUX_AX_REG_EN to put AW and AR behind a
// 2-entry spill register (1 cycle latency, full throughput); otherwise the
// address channels are combinational.
module axi_nto1_mux
  import axi_nto1_mux_pkg::*;
#(
  parameter int unsigned NoMasters    = 2,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned MaxTrans     = 8,
  parameter int unsigned WFifoDepth   = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  axi_nto1_mux_if.slave  mst,
  axi_nto1_mux_if.master slv
);
  localparam int unsigned N      = NoMasters;
  localparam int unsigned IdxW   = idx_w(N);
  localparam int unsigned MstAxW = ax_w(AxiIdWidth, AxiAddrWidth);
  localparam int unsigned SlvAxW = MstAxW + IdxW;
  localparam int unsigned MstBW  = b_w(AxiIdWidth);
  localparam int unsigned SlvBW  = MstBW + IdxW;
  localparam int unsigned MstRW  = r_w(AxiIdWidth, AxiDataWidth);
  localparam int unsigned SlvRW  = MstRW + IdxW;
  localparam int unsigned CntW   = cnt_w(MaxTrans);
  localparam int unsigned WPtrW  = ptr_w(WFifoDepth);

  typedef logic [IdxW-1:0]  idx_t;
  typedef logic [CntW-1:0]  cnt_t;
  typedef logic [WPtrW-1:0] wf_ptr_t;
  typedef logic [WPtrW:0]   wf_cnt_t;

  localparam cnt_t    MaxCnt  = cnt_t'(MaxTrans);
  localparam wf_cnt_t WfDepth = wf_cnt_t'(WFifoDepth);

  // Address channels side by side: index 0 = AW, 1 = AR.
  logic [1:0][N-1:0]      ax_req, ax_gnt;
  logic [1:0][IdxW-1:0]   ax_idx;
  logic [1:0]             ax_valid, ax_ready, ax_hs;
  logic [1:0][SlvAxW-1:0] ax_pay;

  cnt_t [N-1:0] wr_cnt_q, rd_cnt_q;
  logic [N-1:0] wr_inc, wr_dec, rd_inc, rd_dec;

  idx_t    wf_mem_q [WFifoDepth];
  wf_ptr_t wf_wr_q, wf_rd_q;
  wf_cnt_t wf_cnt_q;
  logic    wf_full, wf_empty, wf_pop;
  idx_t    wf_head;

  // ---------------- AW / AR arbitration ----------------
  always_comb begin
    ax_req = '0;
    for (int m = 0; m < int'(N); m++) begin
      ax_req[0][m] = mst.awvalid[m] && (wr_cnt_q[m] < MaxCnt) && !wf_full;
      ax_req[1][m] = mst.arvalid[m] && (rd_cnt_q[m] < MaxCnt);
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_arb
    axi_nto1_mux_rr_arb #(.NoReq(N)) i_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (ax_req[c]),
      .lock_i    (ax_valid[c] && !ax_ready[c]),
      .advance_i (ax_hs[c]),
      .gnt_o     (ax_gnt[c]),
      .idx_o     (ax_idx[c]),
      .valid_o   (ax_valid[c])
    );
  end

  assign ax_hs       = ax_valid & ax_ready;
  assign ax_pay[0]   = {ax_idx[0], mst.aw[ax_idx[0]]};
  assign ax_pay[1]   = {ax_idx[1], mst.ar[ax_idx[1]]};
  assign mst.awready = ax_gnt[0] & {N{ax_ready[0]}};
  assign mst.arready = ax_gnt[1] & {N{ax_ready[1]}};

  // ---------------- W grant FIFO ----------------
  assign wf_full  = (wf_cnt_q == WfDepth);
  assign wf_empty = (wf_cnt_q == '0);
  assign wf_head  = wf_mem_q[wf_rd_q];
  assign wf_pop   = slv.wvalid[0] && slv.wready[0] && slv.w[0][0];

  // NOTE: FIFO storage is not reset; only the pointers and count are, and an
  // entry is never read before it has been written.
  always_ff @(posedge clk_i) begin
    if (ax_hs[0]) wf_mem_q[wf_wr_q] <= ax_idx[0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wf_wr_q  <= '0;
      wf_rd_q  <= '0;
      wf_cnt_q <= '0;
    end else begin
      if (ax_hs[0]) wf_wr_q <= (wf_wr_q == wf_ptr_t'(WFifoDepth - 1)) ? '0 : wf_wr_q + wf_ptr_t'(1);
      if (wf_pop)   wf_rd_q <= (wf_rd_q == wf_ptr_t'(WFifoDepth - 1)) ? '0 : wf_rd_q + wf_ptr_t'(1);
      wf_cnt_q <= wf_cnt_q + wf_cnt_t'(ax_hs[0]) - wf_cnt_t'(wf_pop);
    end
  end

  // Only the head master reaches the slave; registered FIFO output means a
  // freshly pushed grant takes effect the following cycle.
  assign slv.w      = mst.w[wf_head];
  assign slv.wvalid = !wf_empty && mst.wvalid[wf_head];
  always_comb begin
    mst.wready = '0;
    for (int m = 0; m < int'(N); m++)
      mst.wready[m] = !wf_empty && (wf_head == idx_t'(m)) && slv.wready[0];
  end

  // ---------------- B / R return routing ----------------
  // Responses carrying an index with no master behind it are accepted and dropped.
  always_comb begin
    mst.bvalid = '0;
    mst.rvalid = '0;
    slv.bready = '1;
    slv.rready = '1;
    for (int m = 0; m < int'(N); m++) begin
      mst.b[m] = slv.b[0][MstBW-1:0];
      mst.r[m] = slv.r[0][MstRW-1:0];
      if (slv.b[0][SlvBW-1 -: IdxW] == idx_t'(m)) begin
        mst.bvalid[m] = slv.bvalid[0];
        slv.bready[0] = mst.bready[m];
      end
      if (slv.r[0][SlvRW-1 -: IdxW] == idx_t'(m)) begin
        mst.rvalid[m] = slv.rvalid[0];
        slv.rready[0] = mst.rready[m];
      end
    end
  end

  // ---------------- Outstanding counters ----------------
  assign wr_inc = ax_gnt[0] & {N{ax_hs[0]}};
  assign rd_inc = ax_gnt[1] & {N{ax_hs[1]}};
  assign wr_dec = mst.bvalid & mst.bready;
  assign rd_dec = mst.rvalid & mst.rready & {N{slv.r[0][0]}};

  // Decrement at zero saturates: stale responses after a reset must not wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      for (int m = 0; m < int'(N); m++) begin
        unique case ({wr_inc[m], wr_dec[m]})
          2'b10:   wr_cnt_q[m] <= wr_cnt_q[m] + cnt_t'(1);
          2'b01:   if (wr_cnt_q[m] != '0) wr_cnt_q[m] <= wr_cnt_q[m] - cnt_t'(1);
          default: ;
        endcase
        unique case ({rd_inc[m], rd_dec[m]})
          2'b10:   rd_cnt_q[m] <= rd_cnt_q[m] + cnt_t'(1);
          2'b01:   if (rd_cnt_q[m] != '0) rd_cnt_q[m] <= rd_cnt_q[m] - cnt_t'(1);
          default: ;
        endcase
      end
    end
  end

  // ---------------- Address output stage ----------------
`ifdef AXI_NTO1_MUX_AX_REG_EN
  logic [1:0]             sp_out_valid, sp_out_ready;
  logic [1:0][SlvAxW-1:0] sp_out;

  for (genvar c = 0; c < 2; c++) begin : g_spill
    logic [SlvAxW-1:0] mem_q [2];
    logic              wr_q, rd_q;
    logic [1:0]        cnt_q;
    logic              pop;

    assign ax_ready[c]     = (cnt_q != 2'd2);
    assign sp_out_valid[c] = (cnt_q != 2'd0);
    assign sp_out[c]       = mem_q[rd_q];
    assign pop             = sp_out_valid[c] && sp_out_ready[c];

    always_ff @(posedge clk_i) begin
      if (ax_hs[c]) mem_q[wr_q] <= ax_pay[c];
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wr_q  <= 1'b0;
        rd_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        if (ax_hs[c]) wr_q <= !wr_q;
        if (pop)      rd_q <= !rd_q;
        cnt_q <= cnt_q + {1'b0, ax_hs[c]} - {1'b0, pop};
      end
    end
  end

  assign sp_out_ready = {slv.arready[0], slv.awready[0]};
  assign slv.aw       = sp_out[0];
  assign slv.awvalid  = sp_out_valid[0];
  assign slv.ar       = sp_out[1];
  assign slv.arvalid  = sp_out_valid[1];
`else
  assign ax_ready    = {slv.arready[0], slv.awready[0]};
  assign slv.aw      = ax_pay[0];
  assign slv.awvalid = ax_valid[0];
  assign slv.ar      = ax_pay[1];
  assign slv.arvalid = ax_valid[1];
`endif

endmodule

// File: tb/tb_axi_nto1_mux.sv
// Directed bench for axi_nto1_mux: two masters, 4-bit master IDs, MaxTrans=2.
module tb_axi_nto1_mux;
  localparam int unsigned N    = 2;
  localparam int unsigned IdW  = 4;
  localparam int unsigned AxW  = 65;   // 4 + 32 + 29
  localparam int unsigned SAxW = 66;
  localparam int unsigned WW   = 73;   // 64 + 8 + 1

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  axi_nto1_mux_if #(.NoPorts(N), .IdWidth(IdW),     .AddrWidth(32), .DataWidth(64)) mst_if ();
  axi_nto1_mux_if #(.NoPorts(1), .IdWidth(IdW + 1), .AddrWidth(32), .DataWidth(64)) slv_if ();

  axi_nto1_mux #(
    .NoMasters(N), .AxiIdWidth(IdW), .AxiAddrWidth(32), .AxiDataWidth(64),
    .MaxTrans(2), .WFifoDepth(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .mst    (mst_if),
    .slv    (slv_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic logic [AxW-1:0] mk_ax(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0};
  endfunction

  function automatic logic [WW-1:0] beat(input int k, input logic last);
    return {64'hA0A0_0000_0000_0000 | 64'(k), 8'hFF, last};
  endfunction

  initial begin
    mst_if.aw = '0; mst_if.awvalid = '0; mst_if.w = '0; mst_if.wvalid = '0; mst_if.bready = '0;
    mst_if.ar = '0; mst_if.arvalid = '0; mst_if.rready = '0;
    slv_if.awready = '0; slv_if.wready = '0; slv_if.b = '0; slv_if.bvalid = '0;
    slv_if.arready = '0; slv_if.r = '0; slv_if.rvalid = '0;

    // ---- reset state ----
    repeat (2) next_cycle();
    settle();
    check("rst_awvalid", slv_if.awvalid, 1'b0);
    check("rst_arvalid", slv_if.arvalid, 1'b0);
    check("rst_wvalid",  slv_if.wvalid,  1'b0);
    check("rst_bvalid",  mst_if.bvalid,  2'b00);
    check("rst_rvalid",  mst_if.rvalid,  2'b00);
    check("rst_arready", mst_if.arready, 2'b00);
    next_cycle();
    rst_ni = 1'b1;

    // ---- 1: round-robin AR, ID prefix ----
    mst_if.ar[0] = mk_ax(4'h3, 32'h1000, 8'd0);
    mst_if.ar[1] = mk_ax(4'h3, 32'h2000, 8'd0);
    mst_if.arvalid = 2'b11;
    slv_if.arready = 1'b1;
    settle();
    check("t1_arid0",    slv_if.ar[0][SAxW-1 -: 5], 5'h03);
    check("t1_arpay0",   slv_if.ar[0], {1'b0, mk_ax(4'h3, 32'h1000, 8'd0)});
    check("t1_arready0", mst_if.arready, 2'b01);
    next_cycle();
    mst_if.arvalid = 2'b10;
    settle();
    check("t1_arid1",    slv_if.ar[0][SAxW-1 -: 5], 5'h13);
    check("t1_arready1", mst_if.arready, 2'b10);
    next_cycle();
    mst_if.arvalid = 2'b00;

    // ---- 3: R routing by ID MSBs ----
    slv_if.r[0] = {5'h1A, 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1};
    slv_if.rvalid = 1'b1;
    mst_if.rready = 2'b11;
    settle();
    check("t3_rvalid",  mst_if.rvalid, 2'b10);
    check("t3_r1",      mst_if.r[1], {4'hA, 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1});
    check("t3_rready",  slv_if.rready, 1'b1);
    next_cycle();
    slv_if.r[0] = {5'h03, 64'h0, 2'b00, 1'b1};
    mst_if.rready = 2'b10;
    settle();
    check("t3_rvalid_m0", mst_if.rvalid, 2'b01);
    check("t3_rready_stall", slv_if.rready, 1'b0);
    next_cycle();
    mst_if.rready = 2'b11;
    next_cycle();
    slv_if.rvalid = 1'b0;

    // ---- 4: outstanding read limit (MaxTrans=2) ----
    mst_if.ar[0] = mk_ax(4'h1, 32'h4000, 8'd0);
    mst_if.arvalid = 2'b01;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t4_accept", mst_if.arready, 2'b01);
      next_cycle();
    end
    settle();
    check("t4_block_rdy", mst_if.arready, 2'b00);
    check("t4_block_vld", slv_if.arvalid, 1'b0);
    next_cycle();
    slv_if.r[0] = {5'h01, 64'h0, 2'b00, 1'b0};   // non-last beat
    slv_if.rvalid = 1'b1;
    mst_if.rready = 2'b01;
    next_cycle();
    slv_if.r[0] = {5'h01, 64'h0, 2'b00, 1'b1};
    settle();
    check("t4_nonlast_hold", mst_if.arready, 2'b00);
    next_cycle();
    slv_if.rvalid = 1'b0;
    settle();
    check("t4_release_rdy", mst_if.arready, 2'b01);
    check("t4_release_id",  slv_if.ar[0][SAxW-1 -: 5], 5'h01);
    next_cycle();
    mst_if.arvalid = 2'b00;
    slv_if.rvalid = 1'b1;   // drain m0 to zero outstanding
    repeat (2) next_cycle();
    slv_if.rvalid = 1'b0;

    // ---- 5: grant lock while slave stalls ----
    slv_if.arready = 1'b0;
    mst_if.ar[0] = mk_ax(4'h6, 32'h5000, 8'd0);
    mst_if.ar[1] = mk_ax(4'h7, 32'h5100, 8'd0);
    mst_if.arvalid = 2'b01;
    settle();
    check("t5_first_id", slv_if.ar[0][SAxW-1 -: 5], 5'h06);
    next_cycle();
    mst_if.arvalid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t5_locked_pay", slv_if.ar[0], {1'b0, mk_ax(4'h6, 32'h5000, 8'd0)});
      check("t5_locked_rdy", mst_if.arready, 2'b00);
      next_cycle();
    end
    slv_if.arready = 1'b1;
    settle();
    check("t5_m0_hs", mst_if.arready, 2'b01);
    next_cycle();
    mst_if.arvalid = 2'b10;
    settle();
    check("t5_m1_id",  slv_if.ar[0][SAxW-1 -: 5], 5'h17);
    check("t5_m1_rdy", mst_if.arready, 2'b10);
    next_cycle();
    mst_if.arvalid = 2'b00;

    // ---- 2: W routed by grant FIFO ----
    mst_if.aw[1] = mk_ax(4'h2, 32'h3000, 8'd3);
    mst_if.awvalid = 2'b10;
    slv_if.awready = 1'b1;
    slv_if.wready = 1'b1;
    mst_if.w[0] = beat(99, 1'b1);
    mst_if.w[1] = beat(0, 1'b0);
    mst_if.wvalid = 2'b11;
    settle();
    check("t2_awid",     slv_if.aw[0][SAxW-1 -: 5], 5'h12);
    check("t2_awready",  mst_if.awready, 2'b10);
    check("t2_no_fall",  slv_if.wvalid, 1'b0);
    check("t2_no_wrdy",  mst_if.wready, 2'b00);
    next_cycle();
    mst_if.awvalid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mst_if.w[1] = beat(k, k == 3);
      settle();
      check("t2_wvalid", slv_if.wvalid, 1'b1);
      check("t2_wdata",  slv_if.w[0], beat(k, k == 3));
      check("t2_wready", mst_if.wready, 2'b10);
      next_cycle();
    end
    settle();
    check("t2_empty_vld", slv_if.wvalid, 1'b0);
    check("t2_empty_rdy", mst_if.wready, 2'b00);
    next_cycle();
    mst_if.wvalid = 2'b00;
    slv_if.b[0] = {5'h12, 2'b00};
    slv_if.bvalid = 1'b1;
    mst_if.bready = 2'b00;
    settle();
    check("t2_bvalid",  mst_if.bvalid, 2'b10);
    check("t2_b1",      mst_if.b[1], {4'h2, 2'b00});
    check("t2_bstall",  slv_if.bready, 1'b0);
    next_cycle();
    mst_if.bready = 2'b10;
    settle();
    check("t2_bready",  slv_if.bready, 1'b1);
    next_cycle();
    slv_if.bvalid = 1'b0;

    // ---- 6: reset mid-burst, stale B drains ----
    mst_if.aw[0] = mk_ax(4'h5, 32'h6000, 8'd3);
    mst_if.awvalid = 2'b01;
    settle();
    check("t6_aw_hs", mst_if.awready, 2'b01);
    next_cycle();
    mst_if.awvalid = 2'b00;
    mst_if.wvalid = 2'b01;
    mst_if.w[0] = beat(0, 1'b0);
    settle();
    check("t6_beat0", slv_if.wvalid, 1'b1);
    next_cycle();
    mst_if.w[0] = beat(1, 1'b0);
    next_cycle();
    mst_if.w[0] = beat(2, 1'b0);
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
    settle();
    check("t6_rst_wvalid",  slv_if.wvalid, 1'b0);
    check("t6_rst_wready",  mst_if.wready, 2'b00);
    check("t6_rst_awvalid", slv_if.awvalid, 1'b0);
    check("t6_rst_arvalid", slv_if.arvalid, 1'b0);
    next_cycle();
    mst_if.wvalid = 2'b00;
    slv_if.b[0] = {5'h05, 2'b10};
    slv_if.bvalid = 1'b1;
    mst_if.bready = 2'b01;
    settle();
    check("t6_stale_b", mst_if.bvalid, 2'b01);
    next_cycle();
    slv_if.bvalid = 1'b0;
    mst_if.awvalid = 2'b01;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t6_aw_after", mst_if.awready, 2'b01);
      next_cycle();
    end
    settle();
    check("t6_aw_limit", mst_if.awready, 2'b00);
    next_cycle();
    mst_if.awvalid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
